// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the two-requester shared-ALU arbiter.
package alu_arb_pkg;

   localparam int NREQ = 2;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOR = 3'b101;
   localparam logic [2:0] OP_SLL = 3'b110;
   localparam logic [2:0] OP_SRA = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU clients (master) and the arbiter (slave).
interface alu_arbiter_if
   import alu_arb_pkg::*;
   #(parameter int n = 32) ();

   logic [NREQ-1:0] req_valid;
   logic [NREQ-1:0] req_ready;
   logic [n-1:0]    req_a0, req_b0;
   logic [n-1:0]    req_a1, req_b1;
   logic [2:0]      req_op0, req_op1;
   logic [NREQ-1:0] rsp_valid;
   logic [NREQ-1:0] rsp_ready;
   logic [n-1:0]    rsp_result;
   logic            rsp_zero;
   logic            busy;

   modport master (
      output req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, busy
   );

   modport slave (
      input  req_valid, req_a0, req_b0, req_a1, req_b1, req_op0, req_op1, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, busy
   );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational ALU shared by both requesters; shifts take the amount from a[4:0].
module alu
   import alu_arb_pkg::*;
   #(parameter int n = 32) (
   input  logic [n-1:0] a_i,
   input  logic [n-1:0] b_i,
   input  logic [2:0]   op_i,
   output logic [n-1:0] y_o,
   output logic         zero_o
);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_NOR:  y_o = ~(a_i | b_i);
         OP_SLL:  y_o = b_i << a_i[4:0];
         OP_SRA:  y_o = $signed(b_i) >>> a_i[4:0];
         default: y_o = '0;
      endcase
   end

   assign zero_o = (y_o == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for one shared ALU: accept in IDLE, compute in EXEC,
// hold the registered result in RESP until the owning requester takes it.
module alu_arbiter
   import alu_arb_pkg::*;
   #(parameter int n = 32) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);

   state_e          state_q;
   logic [n-1:0]    a_q, b_q, result_q;
   logic [2:0]      op_q;
   logic            owner_q, last_owner_q, zero_q, busy_q;
   logic [NREQ-1:0] rsp_valid_q;

   logic            grant_d;
   logic [NREQ-1:0] req_ready_d;
   logic [n-1:0]    alu_y;
   logic            alu_zero;

   // Contested grant goes to whoever did not own the last completed op.
   always_comb begin
      grant_d = bus.req_valid[1];
      if (&bus.req_valid) grant_d = ~last_owner_q;
      req_ready_d = '0;
      if (state_q == IDLE && rst_n && |bus.req_valid) req_ready_d[grant_d] = 1'b1;
   end

   alu #(.n(n)) u_alu (
      .a_i    (a_q),
      .b_i    (b_q),
      .op_i   (op_q),
      .y_o    (alu_y),
      .zero_o (alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         result_q     <= '0;
         zero_q       <= 1'b0;
         rsp_valid_q  <= '0;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_ready_d) begin
                  owner_q <= grant_d;
                  a_q     <= grant_d ? bus.req_a1  : bus.req_a0;
                  b_q     <= grant_d ? bus.req_b1  : bus.req_b0;
                  op_q    <= grant_d ? bus.req_op1 : bus.req_op0;
                  busy_q  <= 1'b1;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               result_q    <= alu_y;
               zero_q      <= alu_zero;
               rsp_valid_q <= owner_q ? 2'b10 : 2'b01;
               state_q     <= RESP;
            end
            RESP: begin
               if (bus.rsp_ready[owner_q]) begin
                  last_owner_q <= owner_q;
                  rsp_valid_q  <= '0;
                  busy_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end
            default: begin
               rsp_valid_q <= '0;
               busy_q      <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = req_ready_d;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed vector table, contest/reset sequences and a
// randomized transaction-level round-robin model.
module tb_alu_arbiter;
   import alu_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if #(.n(32)) bus ();
   alu_arbiter #(.n(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          r;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        z;
      int          hold;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Reference ALU from arithmetic definitions (powers of two, floor division).
   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint p = 1;
      longint sv, q;
      int sh;
      sh = int'(a % 32);
      for (int i = 0; i < sh; i++) p = p * 2;
      case (op)
         OP_ADD: return a + b;
         OP_SUB: return a - b;
         OP_AND: return a & b;
         OP_OR:  return a | b;
         OP_XOR: return a ^ b;
         OP_NOR: return ~(a | b);
         OP_SLL: return 32'(longint'(b) * p);
         default: begin
            sv = longint'($signed(b));
            q  = sv / p;
            if (sv < 0 && (sv % p) != 0) q = q - 1;
            return 32'(q);
         end
      endcase
   endfunction

   task automatic drive_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (r == 0) begin bus.req_op0 = op; bus.req_a0 = a; bus.req_b0 = b; end
      else        begin bus.req_op1 = op; bus.req_a1 = a; bus.req_b1 = b; end
   endtask

   task automatic scramble_inputs();
      bus.req_a0 = $urandom; bus.req_b0 = $urandom; bus.req_op0 = 3'($urandom);
      bus.req_a1 = $urandom; bus.req_b1 = $urandom; bus.req_op1 = 3'($urandom);
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge, DUT idle again.
   task automatic run_txn(input vec_t v);
      logic [1:0] oh;
      oh = (v.r == 0) ? 2'b01 : 2'b10;
      drive_req(v.r, v.op, v.a, v.b);
      bus.req_valid = oh;
      #1;
      check("req_ready_grant", 32'(bus.req_ready), 32'(oh));
      @(negedge clk);
      bus.req_valid = 2'b00;
      scramble_inputs();
      check("exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("exec_busy", 32'(bus.busy), 32'd1);
      @(negedge clk);
      check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
      check("rsp_result", bus.rsp_result, v.res);
      check("rsp_zero", 32'(bus.rsp_zero), 32'(v.z));
      check("resp_req_ready", 32'(bus.req_ready), 32'd0);
      for (int h = 0; h < v.hold; h++) begin
         bus.rsp_ready = ~oh;
         bus.req_valid = 2'($urandom);
         @(negedge clk);
         #1;
         check("hold_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
         check("hold_rsp_result", bus.rsp_result, v.res);
         check("hold_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = oh;
      @(negedge clk);
      bus.rsp_ready = 2'b00;
      check("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("post_busy", 32'(bus.busy), 32'd0);
   endtask

   task automatic wait_rsp(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus.rsp_valid != 2'b00) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL wait_rsp: got timeout expected rsp_valid within 10 cycles");
      end
   endtask

   initial begin
      bit          ok;
      logic [31:0] exp;
      logic [1:0]  oh;
      int          g, last;
      logic [1:0]  v;

      vecs[0] = '{0, OP_ADD, 32'd5,        32'd7,          32'd12,         1'b0, 0};
      vecs[1] = '{1, OP_SUB, 32'd9,        32'd9,          32'd0,          1'b1, 0};
      vecs[2] = '{0, OP_SRA, 32'd4,        32'h8000_0000,  32'hF800_0000,  1'b0, 5};
      vecs[3] = '{1, OP_SLL, 32'd33,       32'h4000_0001,  32'h8000_0002,  1'b0, 0};
      vecs[4] = '{0, OP_NOR, 32'd0,        32'd0,          32'hFFFF_FFFF,  1'b0, 0};
      vecs[5] = '{1, OP_AND, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0,  1'b0, 2};
      vecs[6] = '{0, OP_ADD, 32'hFFFF_FFFF, 32'd1,         32'd0,          1'b1, 0};
      vecs[7] = '{1, OP_SUB, 32'd0,        32'd1,          32'hFFFF_FFFF,  1'b0, 1};
      vecs[8] = '{0, OP_SRA, 32'd31,       32'h7FFF_FFFF,  32'd0,          1'b1, 0};

      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b00;
      scramble_inputs();
      repeat (2) @(negedge clk);
      check("reset_req_ready", 32'(bus.req_ready), 32'd0);
      check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("reset_result", bus.rsp_result, 32'd0);
      check("reset_zero", 32'(bus.rsp_zero), 32'd0);
      check("reset_busy", 32'(bus.busy), 32'd0);
      bus.req_valid = 2'b00;
      rst_n = 1'b1;
      @(negedge clk);

      foreach (vecs[i]) run_txn(vecs[i]);

      // Contest straight out of reset: requester 0 first, then alternating.
      rst_n = 1'b0;
      @(negedge clk);
      drive_req(0, OP_OR, 32'hF0, 32'h0F);
      drive_req(1, OP_XOR, 32'hFF, 32'h0F);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_rsp(ok);
         if (!ok) break;
         check("contest_owner", 32'(bus.rsp_valid), (k == 1) ? 32'd2 : 32'd1);
         check("contest_result", bus.rsp_result, (k == 1) ? 32'hF0 : 32'hFF);
         @(negedge clk);
      end
      bus.req_valid = 2'b00;
      bus.rsp_ready = 2'b00;
      @(negedge clk);
      while (bus.busy) begin
         bus.rsp_ready = 2'b11;
         @(negedge clk);
      end
      bus.rsp_ready = 2'b00;

      // Requester 0 completes, so without reset a contest would go to 1.
      run_txn('{0, OP_XOR, 32'h1234, 32'h00FF, 32'h12CB, 1'b0, 0});
      drive_req(0, OP_ADD, 32'd100, 32'd1);
      bus.req_valid = 2'b01;
      @(negedge clk);
      bus.req_valid = 2'b00;
      check("pre_reset_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_exec_busy", 32'(bus.busy), 32'd0);
      check("rst_exec_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_exec_result", bus.rsp_result, 32'd0);
      check("rst_exec_req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_no_response", 32'(bus.rsp_valid), 32'd0);
      drive_req(0, OP_AND, 32'hFF, 32'h0F);
      drive_req(1, OP_OR, 32'hFF, 32'h0F);
      bus.req_valid = 2'b11;
      #1;
      check("rst_contest_grant", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 2'b00;
      @(negedge clk);
      check("rst_contest_result", bus.rsp_result, 32'h0F);
      bus.rsp_ready = 2'b01;
      @(negedge clk);
      bus.rsp_ready = 2'b00;

      // Randomized traffic against a transaction-level round-robin model.
      last = 0;
      for (int it = 0; it < 250; it++) begin
         v = 2'($urandom_range(0, 3));
         scramble_inputs();
         if ($urandom_range(0, 3) == 0) begin bus.req_a0 = bus.req_b0; bus.req_a1 = bus.req_b1; end
         bus.req_valid = v;
         #1;
         if (v == 2'b00) begin
            check("rand_idle_ready", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
            continue;
         end
         g  = (v == 2'b11) ? (1 - last) : ((v == 2'b10) ? 1 : 0);
         oh = (g == 0) ? 2'b01 : 2'b10;
         exp = (g == 0) ? ref_alu(bus.req_op0, bus.req_a0, bus.req_b0)
                        : ref_alu(bus.req_op1, bus.req_a1, bus.req_b1);
         check("rand_grant", 32'(bus.req_ready), 32'(oh));
         @(negedge clk);
         bus.req_valid = 2'($urandom);
         scramble_inputs();
         #1;
         check("rand_exec_ready", 32'(bus.req_ready), 32'd0);
         @(negedge clk);
         bus.req_valid = 2'($urandom);
         scramble_inputs();
         #1;
         check("rand_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
         check("rand_result", bus.rsp_result, exp);
         check("rand_zero", 32'(bus.rsp_zero), 32'(exp == 32'd0));
         check("rand_resp_ready", 32'(bus.req_ready), 32'd0);
         repeat ($urandom_range(0, 3)) begin
            bus.rsp_ready = ~oh & 2'($urandom);
            @(negedge clk);
            #1;
            check("rand_hold_result", bus.rsp_result, exp);
         end
         bus.rsp_ready = oh;
         @(negedge clk);
         bus.rsp_ready = 2'b00;
         bus.req_valid = 2'b00;
         last = g;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
